fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx_if.sv | 34 +++
 rtl/fifo_uart_tx.sv | 159 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Bundles the FIFO read port, transmit enable and serial-side status of fifo_uart_tx.
// Latency: none; this is wiring only.
// Backpressure: none here; the transmitter paces FIFO reads through fifo_rd.
interface fifo_uart_tx_if;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       frame_done;

    // Transmitter side: consumes FIFO flags/data and drives the line and status.
    modport master (
        input  tx_en,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd,
        output tx,
        output busy,
        output frame_done
    );

    // Environment side: owns the FIFO and the enable, observes the line.
    modport slave (
        output tx_en,
        output fifo_empty,
        output fifo_data,
        input  fifo_rd,
        input  tx,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO read port and sends each as an async 8N1 frame (8E1 with UART_TX_PARITY_EN).
// Latency: IDLE decision -> FETCH -> LOAD -> START; each frame is 10 (11 with parity) bit periods.
// Backpressure: reads only when tx_en=1 and the FIFO is non-empty; a started frame always completes.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DIV_WIDTH    = 16
) (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd6;
`endif

    // Last divider value of a bit period; the counter never goes past it.
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(CLKS_PER_BIT - 1);

    logic [2:0]           state;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;
    logic                 tx_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    logic bit_end;
    logic start_ok;

    // A bit period ends when the divider reaches its last count.
    assign bit_end  = (div_cnt == DIV_LAST);
    // New frames need permission and data; only looked at in IDLE and the last STOP cycle.
    assign start_ok = bus.tx_en && !bus.fifo_empty;

    // Frame sequencer: tx is updated together with the state so the line level matches the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx_q    <= 1'b1;
                    div_cnt <= '0;
                    if (start_ok) begin
                        state <= S_FETCH;
                    end
                end

                // fifo_rd is high for this single cycle; data arrives during LOAD.
                S_FETCH: begin
                    tx_q    <= 1'b1;
                    div_cnt <= '0;
                    state   <= S_LOAD;
                end

                S_LOAD: begin
                    shift   <= bus.fifo_data;
                    bit_idx <= 3'd0;
                    div_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                    parity  <= 1'b0;
`endif
                    tx_q    <= 1'b0;
                    state   <= S_START;
                end

                S_START: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        bit_idx <= 3'd0;
                        tx_q    <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end

                // Shift LSB first; the next line level is the bit about to move into shift[0].
                S_DATA: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
`ifdef UART_TX_PARITY_EN
                        parity  <= parity ^ shift[0];
`endif
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q  <= parity ^ shift[0];
                            state <= S_PARITY;
`else
                            tx_q  <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        tx_q    <= 1'b1;
                        state   <= S_STOP;
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end
`endif

                // Chain straight into the next fetch when more data is waiting.
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (start_ok) begin
                            state <= S_FETCH;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    div_cnt <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.fifo_rd    = (state == S_FETCH);
    assign bus.busy       = (state != S_IDLE);
    assign bus.frame_done = (state == S_STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed and random stimulus for fifo_uart_tx against a frame-level reference of the serial line.
// Latency: checks fetch, load and every line cycle of each frame.
// Backpressure: a queue models the FIFO with registered read data.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FL = FRAME_BITS * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fifo_uart_tx_if bus();

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DIV_WIDTH    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int rd_count = 0;
    int fd_count = 0;
    int n_push   = 0;
    logic [7:0] q[$];

    // Expected line level for frame bit k: start, 8 data LSB first, optional even parity, stop.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one cycle (negedge to negedge); the FIFO model pops on a sampled fifo_rd.
    task automatic step();
        logic rd_now;
        rd_now = bus.fifo_rd;
        if (bus.frame_done === 1'b1) fd_count++;
        @(posedge clk);
        #1;
        if (rd_now === 1'b1) begin
            rd_count++;
            if (q.size() > 0) bus.fifo_data = q.pop_front();
        end
        bus.fifo_empty = (q.size() == 0);
        @(negedge clk);
        cyc++;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        bus.fifo_empty = 1'b0;
        n_push++;
    endtask

    // Wait (bounded) for FETCH, then check LOAD and every cycle of the frame for byte b.
    task automatic expect_frame(input logic [7:0] b, input int max_wait,
                                input int drop_at, input int abort_at, input string tag);
        int waited;
        waited = 0;
        while (bus.fifo_rd !== 1'b1 && waited < max_wait) begin
            step();
            waited++;
        end
        chk(32'(bus.fifo_rd), 32'd1, {tag, "_fetch_rd"});
        if (bus.fifo_rd !== 1'b1) return;
        chk(32'(bus.busy), 32'd1, {tag, "_fetch_busy"});
        step();
        chk(32'(bus.fifo_rd), 32'd0, {tag, "_load_rd"});
        chk(32'(bus.busy), 32'd1, {tag, "_load_busy"});
        chk(32'(bus.tx), 32'd1, {tag, "_load_tx"});
        step();
        for (int i = 0; i < FL; i++) begin
            chk(32'(bus.tx), 32'(exp_bit(b, i / CPB)), {tag, "_tx"});
            chk(32'(bus.frame_done), 32'(i == FL - 1), {tag, "_frame_done"});
            chk(32'(bus.busy), 32'd1, {tag, "_busy"});
            chk(32'(bus.fifo_rd), 32'd0, {tag, "_rd_in_frame"});
            if (i == drop_at) bus.tx_en = 1'b0;
            if (i == abort_at) begin
                reset = 1'b1;
                return;
            end
            if (i < FL - 1) step();
        end
    endtask

    logic [7:0] rb[4];
    logic [7:0] second;

    initial begin
        bus.tx_en      = 1'b1;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = 8'h00;
        reset          = 1'b1;
        @(negedge clk);
        repeat (3) step();

        // Reset state
        chk(32'(bus.tx), 32'd1, "rst_tx");
        chk(32'(bus.busy), 32'd0, "rst_busy");
        chk(32'(bus.fifo_rd), 32'd0, "rst_rd");
        chk(32'(bus.frame_done), 32'd0, "rst_frame_done");

        // Enabled but empty: nothing happens for 50 cycles
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk(32'(bus.tx), 32'd1, "empty_tx");
            chk(32'(bus.busy), 32'd0, "empty_busy");
            chk(32'(bus.fifo_rd), 32'd0, "empty_rd");
        end

        // Single byte 0xA5
        push(8'hA5);
        expect_frame(8'hA5, 5, -1, -1, "a5");
        step();
        chk(32'(bus.busy), 32'd0, "a5_idle_busy");
        chk(32'(bus.tx), 32'd1, "a5_idle_tx");

        // Back-to-back 0x01, 0xFF
        push(8'h01);
        push(8'hFF);
        expect_frame(8'h01, 5, -1, -1, "b2b0");
        step();
        expect_frame(8'hFF, 0, -1, -1, "b2b1");
        step();
        chk(32'(bus.busy), 32'd0, "b2b_idle_busy");

        // tx_en dropped in the 3rd data bit of 0x3C
        second = 8'($urandom_range(0, 255));
        push(8'h3C);
        push(second);
        expect_frame(8'h3C, 5, 3 * CPB, -1, "txen_drop");
        step();
        chk(32'(bus.busy), 32'd0, "txen_idle_busy");
        chk(32'(bus.tx), 32'd1, "txen_idle_tx");
        for (int i = 0; i < 8; i++) begin
            step();
            chk(32'(bus.fifo_rd), 32'd0, "txen_hold_rd");
            chk(32'(bus.busy), 32'd0, "txen_hold_busy");
        end
        bus.tx_en = 1'b1;
        expect_frame(second, 3, -1, -1, "txen_resume");
        step();

        // Reset during data bit 5, then a fresh frame
        push(8'h5A);
        push(8'hC3);
        expect_frame(8'h5A, 5, -1, 6 * CPB + 1, "abort");
        step();
        chk(32'(bus.tx), 32'd1, "abort_tx");
        chk(32'(bus.busy), 32'd0, "abort_busy");
        chk(32'(bus.fifo_rd), 32'd0, "abort_rd");
        reset = 1'b0;
        expect_frame(8'hC3, 3, -1, -1, "after_abort");
        step();

        // Random bytes, back-to-back
        for (int k = 0; k < 4; k++) begin
            rb[k] = 8'($urandom_range(0, 255));
            push(rb[k]);
        end
        expect_frame(rb[0], 5, -1, -1, "rand");
        for (int k = 1; k < 4; k++) begin
            step();
            expect_frame(rb[k], 0, -1, -1, "rand");
        end
        step();

        // 0x07: parity bit is 1 when parity is built in
        push(8'h07);
        expect_frame(8'h07, 5, -1, -1, "p07");
        step();
        chk(32'(bus.busy), 32'd0, "p07_idle_busy");

        // Totals: every byte read exactly once, one frame_done per completed frame
        step();
        chk(32'(rd_count), 32'(n_push), "total_reads");
        chk(32'(fd_count), 32'(n_push - 1), "total_frame_done");
        chk(32'(q.size()), 32'd0, "fifo_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
